// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: one result bit per cycle, 32 iterations,
// followed by a single write-back cycle during which the core is released.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [XLEN-1:0]       operand_a,
  input  logic [XLEN-1:0]       operand_b,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  output logic                  busy,
  output logic                  stall,
  output logic                  done,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_reg,
  output logic [XLEN-1:0]       wb_data
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_count;
  logic                  r_sel_hi;
  logic [XLEN-1:0]       r_b;
  logic [REG_ADDR_W-1:0] r_dest;
  logic [XLEN-1:0]       r_hi;
  logic [XLEN-1:0]       r_lo;
  logic                  r_done;
  logic                  r_wb_en;
  logic [REG_ADDR_W-1:0] r_wb_reg;
  logic [XLEN-1:0]       r_wb_data;

  logic [XLEN:0]   w_add;
  logic [XLEN:0]   w_rsh;
  logic            w_ge;
  logic [XLEN-1:0] w_sub;
  logic [XLEN-1:0] w_hi_next;
  logic [XLEN-1:0] w_lo_next;
  logic [XLEN-1:0] w_result;

  // Next {hi,lo} for one iteration; r_hi/r_lo hold {R,Q} while dividing.
  always_comb begin
    w_add     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    w_rsh     = {r_hi, r_lo[XLEN-1]};
    w_ge      = (w_rsh >= {1'b0, r_b});
    // The restored remainder is always below r_b, so the low bits of the difference suffice.
    w_sub     = w_rsh[XLEN-1:0] - r_b;
    w_hi_next = {XLEN{1'b0}};
    w_lo_next = {XLEN{1'b0}};
    if (r_state == S_DIV) begin
      w_hi_next = w_ge ? w_sub : w_rsh[XLEN-1:0];
      w_lo_next = {r_lo[XLEN-2:0], w_ge};
    end else begin
      w_hi_next = w_add[XLEN:1];
      w_lo_next = {w_add[0], r_lo[XLEN-1:1]};
    end
    w_result = r_sel_hi ? w_hi_next : w_lo_next;
  end

  // Control FSM, iteration datapath and registered write-back outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_count   <= {CNT_W{1'b0}};
      r_sel_hi  <= 1'b0;
      r_b       <= {XLEN{1'b0}};
      r_dest    <= {REG_ADDR_W{1'b0}};
      r_hi      <= {XLEN{1'b0}};
      r_lo      <= {XLEN{1'b0}};
      r_done    <= 1'b0;
      r_wb_en   <= 1'b0;
      r_wb_reg  <= {REG_ADDR_W{1'b0}};
      r_wb_data <= {XLEN{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sel_hi <= op[0];
            r_b      <= operand_b;
            r_dest   <= dest_reg;
            r_count  <= {CNT_W{1'b0}};
            r_hi     <= {XLEN{1'b0}};
            r_lo     <= operand_a;
            r_state  <= op[1] ? S_DIV : S_MUL;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_MUL, S_DIV: begin
          r_hi    <= w_hi_next;
          r_lo    <= w_lo_next;
          r_count <= r_count + CNT_W'(1);
          if (r_count == LAST_ITER) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_wb_en   <= (r_dest != {REG_ADDR_W{1'b0}});
            r_wb_reg  <= r_dest;
            r_wb_data <= w_result;
          end else begin
            r_state   <= r_state;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_done    <= 1'b0;
          r_wb_en   <= 1'b0;
          r_wb_reg  <= {REG_ADDR_W{1'b0}};
          r_wb_data <= {XLEN{1'b0}};
        end
        default: begin
          r_state   <= S_IDLE;
          r_done    <= 1'b0;
          r_wb_en   <= 1'b0;
          r_wb_reg  <= {REG_ADDR_W{1'b0}};
          r_wb_data <= {XLEN{1'b0}};
        end
      endcase
    end
  end

  // Stall drops in DONE so the core retires the instruction alongside the write-back.
  assign busy    = (r_state != S_IDLE);
  assign stall   = ((r_state == S_IDLE) && start) || (r_state == S_MUL) || (r_state == S_DIV);
  assign done    = r_done;
  assign wb_en   = r_wb_en;
  assign wb_reg  = r_wb_reg;
  assign wb_data = r_wb_data;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected write-backs are queued at issue time
// and compared when the unit signals done.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  dest_reg;
  logic        busy, stall, done, wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        en;
  } exp_t;

  typedef struct {
    bit          seen;
    int          lat;
    bit          stall_ok;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        en;
    logic        stall_d;
    logic        busy_d;
    logic        done_after;
    logic        busy_after;
    logic        en_after;
    logic [31:0] data_after;
  } obs_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .dest_reg(dest_reg),
    .busy(busy), .stall(stall), .done(done), .wb_en(wb_en),
    .wb_reg(wb_reg), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Drive one request at the current negedge; scramble inputs after acceptance.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit push);
    exp_t e;
    start = 1'b1; op = o; operand_a = a; operand_b = b; dest_reg = rd;
    if (push) begin
      e.data = model(o, a, b); e.rd = rd; e.en = (rd != 5'd0);
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom_range(3, 0));
    operand_a = $urandom; operand_b = $urandom;
    dest_reg = 5'($urandom_range(31, 0));
  endtask

  // Wait (bounded) for done and record what the unit showed; optional stray start pulses.
  task automatic collect(input bit poke, output obs_t ob);
    int cyc;
    ob = '{default: '0};
    ob.stall_ok = 1'b1;
    cyc = 1;
    while (!ob.seen && cyc <= 40) begin
      if (done === 1'b1) begin
        ob.seen = 1'b1;
        ob.lat = cyc;
      end else begin
        if (stall !== 1'b1 || wb_en !== 1'b0) ob.stall_ok = 1'b0;
        if (poke && cyc == 5) begin
          start = 1'b1; op = 2'b00; operand_a = 32'd9; operand_b = 32'd9; dest_reg = 5'd1;
        end else if (poke && cyc == 6) begin
          start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (ob.seen) begin
      ob.data = wb_data; ob.rd = wb_reg; ob.en = wb_en;
      ob.stall_d = stall; ob.busy_d = busy;
      if (poke) begin
        start = 1'b1; op = 2'b01; operand_a = 32'd77; operand_b = 32'd5; dest_reg = 5'd2;
      end
      @(negedge clk);
      ob.done_after = done; ob.busy_after = busy;
      ob.en_after = wb_en; ob.data_after = wb_data;
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00;
    operand_a = 32'd0; operand_b = 32'd0; dest_reg = 5'd0;
    #2;
    total++;
    if ({busy, stall, done, wb_en} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000", {busy, stall, done, wb_en});
    end
    total++;
    if (wb_data !== 32'd0 || wb_reg !== 5'd0) begin
      bad++; $display("FAIL reset_wb: got data=%h reg=%0d want 0/0", wb_data, wb_reg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul_timing();
    obs_t ob;
    exp_t e;
    issue(2'b00, 32'd7, 32'd6, 5'd5, 1'b1);
    collect(1'b0, ob);
    e = sb.pop_front();
    total++;
    if (!ob.seen || ob.lat != 33) begin
      bad++; $display("FAIL mul_latency: got seen=%0b lat=%0d want 1/33", ob.seen, ob.lat);
    end
    total++;
    if (!ob.stall_ok) begin
      bad++; $display("FAIL mul_stall: stall low or wb_en high before DONE, want stall=1 wb_en=0");
    end
    total++;
    if (ob.data !== e.data || ob.rd !== e.rd || ob.en !== e.en) begin
      bad++; $display("FAIL mul_7x6: got %h/%0d/%b want %h/%0d/%b", ob.data, ob.rd, ob.en, e.data, e.rd, e.en);
    end
    total++;
    if (ob.stall_d !== 1'b0 || ob.busy_d !== 1'b1) begin
      bad++; $display("FAIL done_state: got stall=%b busy=%b want 0/1", ob.stall_d, ob.busy_d);
    end
    total++;
    if ({ob.done_after, ob.busy_after, ob.en_after} !== 3'b000 || ob.data_after !== 32'd0) begin
      bad++; $display("FAIL after_done: got done=%b busy=%b en=%b data=%h want 0/0/0/0",
                      ob.done_after, ob.busy_after, ob.en_after, ob.data_after);
    end
  endtask

  task automatic test_arith();
    logic [1:0]  ops[9] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11, 2'b00, 2'b10, 2'b11};
    logic [31:0] as[9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'd5, 32'd5,
                            32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    logic [31:0] bs[9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'd0, 32'd0,
                            32'h9ABC_DEF0, 32'd1_000, 32'h0001_0003};
    obs_t ob;
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      issue(ops[i], as[i], bs[i], 5'(i + 10), 1'b1);
      collect(1'b0, ob);
      e = sb.pop_front();
      total++;
      if (!ob.seen || ob.data !== e.data || ob.rd !== e.rd || ob.en !== e.en) begin
        bad++; $display("FAIL arith_%0d: got seen=%0b %h/%0d/%b want %h/%0d/%b",
                        i, ob.seen, ob.data, ob.rd, ob.en, e.data, e.rd, e.en);
      end
    end
  endtask

  task automatic test_ignore_start();
    obs_t ob;
    exp_t e;
    issue(2'b10, 32'd100, 32'd7, 5'd3, 1'b1);
    collect(1'b1, ob);
    e = sb.pop_front();
    total++;
    if (!ob.seen || ob.lat != 33 || ob.data !== e.data || ob.rd !== e.rd) begin
      bad++; $display("FAIL ignore_start: got lat=%0d %h/%0d want 33 %h/%0d", ob.lat, ob.data, ob.rd, e.data, e.rd);
    end
    total++;
    if (ob.busy_after !== 1'b0) begin
      bad++; $display("FAIL ignore_busy: got busy=%b after DONE want 0", ob.busy_after);
    end
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL ignore_noop: got busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    obs_t ob;
    exp_t e;
    bit quiet;
    issue(2'b10, 32'd1000, 32'd3, 5'd7, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, stall, done, wb_en} !== 4'b0000 || wb_data !== 32'd0 || wb_reg !== 5'd0) begin
      bad++; $display("FAIL mid_reset: got ctrl=%b data=%h reg=%0d want 0", {busy, stall, done, wb_en}, wb_data, wb_reg);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (wb_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin
      bad++; $display("FAIL mid_reset_quiet: got activity after reset want none");
    end
    issue(2'b00, 32'd3, 32'd3, 5'd9, 1'b1);
    collect(1'b0, ob);
    e = sb.pop_front();
    total++;
    if (!ob.seen || ob.data !== e.data || ob.en !== e.en) begin
      bad++; $display("FAIL mid_reset_mul: got %h/%b want %h/%b", ob.data, ob.en, e.data, e.en);
    end
  endtask

  task automatic test_rd0();
    obs_t ob;
    exp_t e;
    issue(2'b00, 32'd2, 32'd3, 5'd0, 1'b1);
    collect(1'b0, ob);
    e = sb.pop_front();
    total++;
    if (!ob.seen || ob.en !== e.en || ob.data !== e.data) begin
      bad++; $display("FAIL rd0: got seen=%0b en=%b data=%h want 1/%b/%h", ob.seen, ob.en, ob.data, e.en, e.data);
    end
  endtask

  task automatic test_back_to_back();
    obs_t ob1, ob2;
    exp_t e1, e2;
    issue(2'b11, 32'hCAFE_F00D, 32'd12345, 5'd20, 1'b1);
    collect(1'b0, ob1);
    issue(2'b01, 32'h8000_0001, 32'h0000_0003, 5'd21, 1'b1);
    collect(1'b0, ob2);
    e1 = sb.pop_front();
    e2 = sb.pop_front();
    total++;
    if (!ob1.seen || ob1.data !== e1.data || ob1.rd !== e1.rd) begin
      bad++; $display("FAIL b2b_first: got %h/%0d want %h/%0d", ob1.data, ob1.rd, e1.data, e1.rd);
    end
    total++;
    if (!ob2.seen || ob2.lat != 33 || ob2.data !== e2.data || ob2.rd !== e2.rd) begin
      bad++; $display("FAIL b2b_second: got lat=%0d %h/%0d want 33 %h/%0d", ob2.lat, ob2.data, ob2.rd, e2.data, e2.rd);
    end
  endtask

  initial begin
    test_reset();
    test_mul_timing();
    test_arith();
    test_ignore_start();
    test_reset_mid();
    test_rd0();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
